// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with a CTRL/PRESET/COUNT register map and a level or
// pulsed interrupt request, depending on MODE.
module timer_counter #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic sel, wr_ctrl, wr_preset, periodic;
  logic unused_addr;

  assign unused_addr = ^addr[1:0];
  assign sel         = (addr[31:4] == BASE[31:4]);
  // Only full-word writes are accepted; partial-byte writes are dropped.
  assign wr_ctrl     = sel && (byteen == 4'b1111) && (addr[3:2] == 2'd0);
  assign wr_preset   = sel && (byteen == 4'b1111) && (addr[3:2] == 2'd1);
  assign periodic    = (mode_q == 2'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      en_q     <= 1'b0;
      mode_q   <= 2'd0;
      im_q     <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en_q) state_d = StLoad;
      StLoad:  state_d = StCnt;
      StCnt: begin
        if (!en_q)               state_d = StIdle;
        else if (count_q <= 32'd1) state_d = StInt;
      end
      StInt:   state_d = periodic ? StLoad : StIdle;
      default: state_d = StIdle;
    endcase
    // A CTRL write restarts the sequence from IDLE, even on the INT edge.
    if (wr_ctrl) state_d = StIdle;
  end

  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    // In periodic mode LOAD always follows INT, so the flag becomes a one-cycle pulse.
    if (state_q == StLoad && periodic) flag_d = 1'b0;
    unique case (state_q)
      StLoad: count_d = preset_q;
      StCnt:  if (en_q) count_d = (count_q > 32'd1) ? count_q - 32'd1 : 32'd0;
      StInt: begin
        flag_d = 1'b1;
        if (!periodic) en_d = 1'b0;
      end
      default: ;
    endcase
    if (wr_ctrl) begin
      en_d    = wdata[0];
      mode_d  = wdata[2:1];
      im_d    = wdata[3];
      count_d = count_q;
      flag_d  = 1'b0;
    end
    if (wr_preset) begin
      preset_d = wdata;
      flag_d   = 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (addr[3:2])
        2'd0:    rdata = {28'd0, im_q, mode_q, en_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = '0;
      endcase
    end
    irq = im_q & flag_q;
  end

endmodule
